ysyx_25020037_lsu_axi: RTL

YSYX_25020037_LSU_AXI -- requirements
Module: ysyx_25020037_lsu_axi

---
 rtl/ysyx_25020037_lsu_axi.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ysyx_25020037_lsu_axi.sv
// ysyx_25020037_lsu_axi: single-outstanding load/store unit bridging a pipeline request/response port to AXI4-Lite
module ysyx_25020037_lsu_axi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [TAG_W-1:0]    out_tag,
  output logic [1:0]          out_fault,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [2:0] IDLE = 3'd0, RD_A = 3'd1, RD_D = 3'd2, WR_AW = 3'd3, WR_B = 3'd4, RESP = 3'd5;
  logic [2:0]        st;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  sz_mask;
  logic [BYTES-1:0]  bmask;
  logic              illegal;
  logic              misal;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] lmask;
  logic              sgn;
  logic [DATA_W-1:0] ext;
  // lmask covers the low 8<<size bits; its top set bit locates the load's sign bit
  always_comb begin
    off     = in_addr[OFF_W-1:0];
    sz_mask = OFF_W'((4'd1 << in_op[1:0]) - 4'd1);
    bmask   = BYTES'((9'd1 << (4'd1 << in_op[1:0])) - 9'd1);
    illegal = in_op[3] == in_op[4];
    misal   = ({1'b0, in_op[1:0]} > 3'(OFF_W)) || ((off & sz_mask) != '0);
    lane    = rdata >> {off_q, 3'b000};
    lmask   = ~({DATA_W{1'b1}} << (7'd8 << size_q));
    sgn     = |(lane & (lmask ^ (lmask >> 1)));
    ext     = (lane & lmask) | ((!uns_q && sgn) ? ~lmask : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_tag   <= '0;
      out_fault <= 2'b00;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      awsize    <= 3'd0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      arsize    <= 3'd0;
      rready    <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid && in_ready) begin
          in_ready  <= 1'b0;
          out_tag   <= in_tag;
          size_q    <= in_op[1:0];
          uns_q     <= in_op[2];
          off_q     <= off;
          out_rdata <= '0;
          out_fault <= 2'b00;
          if (illegal || misal) begin
            st        <= RESP;
            out_valid <= 1'b1;
            out_fault <= illegal ? 2'b11 : 2'b01;
          end else if (in_op[3]) begin
            st      <= RD_A;
            arvalid <= 1'b1;
            araddr  <= in_addr;
            arsize  <= {1'b0, in_op[1:0]};
          end else begin
            st      <= WR_AW;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= in_addr;
            awsize  <= {1'b0, in_op[1:0]};
            wdata   <= in_wdata << {off, 3'b000};
            wstrb   <= bmask << off;
          end
        end
        RD_A: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          st      <= RD_D;
        end
        RD_D: if (rvalid) begin
          rready    <= 1'b0;
          out_valid <= 1'b1;
          out_rdata <= (rresp != 2'b00) ? '0 : ext;
          out_fault <= (rresp != 2'b00) ? 2'b10 : 2'b00;
          st        <= RESP;
        end
        WR_AW: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            st     <= WR_B;
          end
        end
        WR_B: if (bvalid) begin
          bready    <= 1'b0;
          out_valid <= 1'b1;
          out_fault <= (bresp != 2'b00) ? 2'b10 : 2'b00;
          st        <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
